smbus_target_responder: RTL and testbench

- Synthesizable SMBus/I2C target (slave) endpoint. It answers one 7-bit address on the downstream side of the I2C filter and provides the far end that the relay forwards master traffic to.
- Decodes START, address, write pointer, and data bytes, and drives ACK and read data open-drain.
- Exposes a simple register-access port to local logic: byte write strobe, and read address with combinational read data.
- Used both as a bench responder for the filter and as a reusable target in the design.

---
 rtl/smbus_target_pkg.sv | 19 +
 rtl/smbus_input_filter.sv | 53 +++++
 rtl/smbus_target_responder.sv | 238 +++++++++++++++++++++++
 tb/tb_smbus_target_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/smbus_target_pkg.sv
// Shared types and bus constants for the SMBus/I2C target responder.
package smbus_target_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_PTR,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/smbus_input_filter.sv
// Conditions one raw open-drain line: 2-flop synchronizer, glitch filter,
// and single-cycle rise/fall pulses derived from the filtered level.
module smbus_input_filter #(
    parameter int GLITCH_CYCLES = 3
) (
    input  logic clock,
    input  logic i_resetn,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = $clog2(GLITCH_CYCLES + 1);

    logic [1:0]    sync_q;
    logic          filt_q, filt_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // The filtered level flips only once the synchronized input has differed
    // from it for GLITCH_CYCLES consecutive samples.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CW'(GLITCH_CYCLES - 1)) begin
                filt_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!i_resetn) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            prev_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], i_raw};
            filt_q <= filt_d;
            prev_q <= filt_q;
            cnt_q  <= cnt_d;
        end
    end

    assign o_level = filt_q;
    assign o_rise  = filt_q & ~prev_q;
    assign o_fall  = ~filt_q & prev_q;

endmodule

// File: rtl/smbus_target_responder.sv
// SMBus/I2C target endpoint with a byte-register access port.
// Optional SCL-low timeout is built when SMBUS_TARGET_SCL_TIMEOUT_EN is defined.
module smbus_target_responder
    import smbus_target_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDRESS = 7'h5A,
    parameter int         NUM_REGS       = 16,
    parameter int         GLITCH_CYCLES  = 3,
    parameter int         TIMEOUT_CYCLES = 3500000
) (
    input  logic                        clock,
    input  logic                        i_resetn,
    input  logic                        i_scl,
    input  logic                        i_sda,
    output logic                        o_sda_oe,
    output logic [$clog2(NUM_REGS)-1:0] o_reg_addr,
    input  logic [7:0]                  i_reg_rdata,
    output logic                        o_reg_wr,
    output logic [7:0]                  o_reg_wdata,
    output logic                        o_busy,
    output state_e                      o_state
);

    localparam int AW = $clog2(NUM_REGS);

    if (NUM_REGS < 2 || NUM_REGS > 256 || (NUM_REGS & (NUM_REGS - 1)) != 0 ||
        TIMEOUT_CYCLES < 1 || GLITCH_CYCLES < 1) begin : g_bad_param
        $error("smbus_target_responder: illegal parameter value");
    end

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    smbus_input_filter #(.GLITCH_CYCLES(GLITCH_CYCLES)) u_scl_filter (
        .clock   (clock),
        .i_resetn(i_resetn),
        .i_raw   (i_scl),
        .o_level (scl_lvl),
        .o_rise  (scl_rise),
        .o_fall  (scl_fall)
    );

    smbus_input_filter #(.GLITCH_CYCLES(GLITCH_CYCLES)) u_sda_filter (
        .clock   (clock),
        .i_resetn(i_resetn),
        .i_raw   (i_sda),
        .o_level (sda_lvl),
        .o_rise  (sda_rise),
        .o_fall  (sda_fall)
    );

    logic start_det, stop_det, timeout;
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    state_e        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    tx_q, tx_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          sda_oe_q, sda_oe_d;
    logic          busy_q, busy_d;
    logic          wr_q, wr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          rw_q, rw_d;
    logic          mack_q, mack_d;

`ifdef SMBUS_TARGET_SCL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = '0;
        timeout  = 1'b0;
        if (!scl_lvl && busy_q) begin
            if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                timeout = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!i_resetn) to_cnt_q <= '0;
        else           to_cnt_q <= to_cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        addr_d    = addr_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        wr_d      = 1'b0;
        wdata_d   = wdata_q;
        rw_d      = rw_q;
        mack_d    = mack_q;

        // Pointer advances the clock after the write strobe so the strobe
        // carries the address the byte was written to.
        if (wr_q) addr_d = addr_q + 1'b1;

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else if (stop_det || timeout) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ADDR, WR_PTR, WR_DATA: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_lvl};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        if (state_q == ADDR) begin
                            if (shift_q[7:1] == TARGET_ADDRESS) begin
                                state_d  = ADDR_ACK;
                                sda_oe_d = 1'b1;
                                rw_d     = shift_q[0];
                            end else begin
                                state_d = IGNORE;
                            end
                        end else if (state_q == WR_PTR) begin
                            addr_d   = shift_q[AW-1:0];
                            sda_oe_d = 1'b1;
                            state_d  = WR_ACK;
                        end else begin
                            wr_d     = 1'b1;
                            wdata_d  = shift_q;
                            sda_oe_d = 1'b1;
                            state_d  = WR_ACK;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (rw_q) begin
                            state_d  = RD_DATA;
                            tx_d     = i_reg_rdata;
                            sda_oe_d = ~i_reg_rdata[7];
                        end else begin
                            state_d  = WR_PTR;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        state_d   = WR_DATA;
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                    end
                end
                RD_DATA: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            state_d  = RD_ACK;
                            sda_oe_d = 1'b0;
                        end else begin
                            tx_d     = {tx_q[6:0], 1'b1};
                            sda_oe_d = ~tx_q[6];
                        end
                    end
                end
                RD_ACK: begin
                    // Advancing on the ACK rising edge lets the next byte's
                    // read data settle before the falling edge captures it.
                    if (scl_rise) begin
                        mack_d = sda_lvl;
                        if (sda_lvl == I2C_ACK) addr_d = addr_q + 1'b1;
                    end else if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (mack_q == I2C_ACK) begin
                            state_d  = RD_DATA;
                            tx_d     = i_reg_rdata;
                            sda_oe_d = ~i_reg_rdata[7];
                        end else begin
                            state_d  = IGNORE;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!i_resetn) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= '0;
            addr_q    <= '0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            rw_q      <= 1'b0;
            mack_q    <= I2C_NACK;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            addr_q    <= addr_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            rw_q      <= rw_d;
            mack_q    <= mack_d;
        end
    end

    // Gated by reset so a transfer in flight lets go of SDA without waiting a clock.
    assign o_sda_oe    = sda_oe_q & i_resetn;
    assign o_reg_addr  = addr_q;
    assign o_reg_wr    = wr_q;
    assign o_reg_wdata = wdata_q;
    assign o_busy      = busy_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_smbus_target_responder.sv
// Directed bench for smbus_target_responder: bit-banged I2C master, register
// model behind the read port, and a write scoreboard.
module tb_smbus_target_responder;
    import smbus_target_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       scl_m;
    logic       sda_m;
    logic       sda_line;
    logic       o_sda_oe;
    logic [3:0] o_reg_addr;
    logic [7:0] i_reg_rdata;
    logic       o_reg_wr;
    logic [7:0] o_reg_wdata;
    logic       o_busy;
    state_e     o_state;

    logic [7:0]  regs [16];
    logic [11:0] exp_q [$];
    logic [11:0] got_q [$];
    logic        oe_seen;
    int          n_checks;
    int          n_fail;

    assign sda_line    = sda_m & ~o_sda_oe;
    assign i_reg_rdata = regs[o_reg_addr];

    smbus_target_responder #(
        .TARGET_ADDRESS(7'h5A),
        .NUM_REGS      (16),
        .GLITCH_CYCLES (3),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clock      (clk),
        .i_resetn   (rst_n),
        .i_scl      (scl_m),
        .i_sda      (sda_line),
        .o_sda_oe   (o_sda_oe),
        .o_reg_addr (o_reg_addr),
        .i_reg_rdata(i_reg_rdata),
        .o_reg_wr   (o_reg_wr),
        .o_reg_wdata(o_reg_wdata),
        .o_busy     (o_busy),
        .o_state    (o_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // write monitor and register model
    always @(negedge clk) begin
        if (rst_n && o_reg_wr) begin
            got_q.push_back({o_reg_addr, o_reg_wdata});
            regs[o_reg_addr] = o_reg_wdata;
        end
        if (o_sda_oe) oe_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // driver tasks
    task automatic i2c_start();
        sda_m = 1'b1; wait_clks(10);
        scl_m = 1'b1; wait_clks(20);
        sda_m = 1'b0; wait_clks(20);
        scl_m = 1'b0; wait_clks(10);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clks(10);
        scl_m = 1'b1; wait_clks(20);
        sda_m = 1'b1; wait_clks(20);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wait_clks(10);
        scl_m = 1'b1; wait_clks(20);
        scl_m = 1'b0; wait_clks(10);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wait_clks(10);
        scl_m = 1'b1; wait_clks(10);
        b = sda_line; wait_clks(10);
        scl_m = 1'b0; wait_clks(10);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        send_bit(master_ack);
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_wr_cnt"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            check({tag, "_wr"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;

        n_checks = 0;
        n_fail   = 0;
        oe_seen  = 1'b0;
        for (int i = 0; i < 16; i++) regs[i] = 8'h00;
        regs[5] = 8'h11;
        regs[6] = 8'h22;
        scl_m = 1'b1;
        sda_m = 1'b1;
        rst_n = 1'b0;
        wait_clks(5);

        check("rst_sda_oe", 32'(o_sda_oe), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_wr", 32'(o_reg_wr), 32'd0);
        check("rst_wdata", 32'(o_reg_wdata), 32'h00);
        check("rst_addr", 32'(o_reg_addr), 32'd0);
        check("rst_state", 32'(o_state), 32'(IDLE));
        rst_n = 1'b1;
        wait_clks(10);

        // write two bytes starting at pointer 3
        exp_q.push_back({4'd3, 8'hA5});
        exp_q.push_back({4'd4, 8'h5C});
        i2c_start();
        check("wr_busy", 32'(o_busy), 32'd1);
        write_byte(8'hB4, ack); check("wr_ack_addr", 32'(ack), 32'd0);
        write_byte(8'h03, ack); check("wr_ack_ptr", 32'(ack), 32'd0);
        write_byte(8'hA5, ack); check("wr_ack_d0", 32'(ack), 32'd0);
        write_byte(8'h5C, ack); check("wr_ack_d1", 32'(ack), 32'd0);
        i2c_stop();
        compare_writes("write");
        check("wr_busy_end", 32'(o_busy), 32'd0);
        check("wr_state_end", 32'(o_state), 32'(IDLE));
        check("wr_addr_end", 32'(o_reg_addr), 32'd5);

        // combined pointer write / repeated START / two-byte read
        i2c_start();
        write_byte(8'hB4, ack); check("rd_ack_addr_w", 32'(ack), 32'd0);
        write_byte(8'h05, ack); check("rd_ack_ptr", 32'(ack), 32'd0);
        i2c_start();
        write_byte(8'hB5, ack); check("rd_ack_addr_r", 32'(ack), 32'd0);
        read_byte(1'b0, rd);    check("rd_byte0", 32'(rd), 32'h11);
        read_byte(1'b1, rd);    check("rd_byte1", 32'(rd), 32'h22);
        check("rd_nack_release", 32'(o_sda_oe), 32'd0);
        check("rd_nack_state", 32'(o_state), 32'(IGNORE));
        i2c_stop();
        check("rd_addr_end", 32'(o_reg_addr), 32'd6);
        compare_writes("read");

        // foreign address is ignored
        oe_seen = 1'b0;
        i2c_start();
        write_byte(8'hA0, ack); check("na_ack_addr", 32'(ack), 32'd1);
        write_byte(8'h12, ack); check("na_ack_data", 32'(ack), 32'd1);
        check("na_state", 32'(o_state), 32'(IGNORE));
        i2c_stop();
        check("na_oe_seen", 32'(oe_seen), 32'd0);
        compare_writes("noaddr");

        // pointer wrap from 15 to 0
        exp_q.push_back({4'd15, 8'hEE});
        exp_q.push_back({4'd0,  8'hFF});
        i2c_start();
        write_byte(8'hB4, ack);
        write_byte(8'h0F, ack);
        write_byte(8'hEE, ack); check("wrap_ack_d0", 32'(ack), 32'd0);
        write_byte(8'hFF, ack); check("wrap_ack_d1", 32'(ack), 32'd0);
        i2c_stop();
        compare_writes("wrap");
        check("wrap_addr_end", 32'(o_reg_addr), 32'd1);

        // mid-byte STOP aborts the byte
        i2c_start();
        write_byte(8'hB4, ack);
        write_byte(8'h02, ack);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        i2c_stop();
        compare_writes("abort");
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_addr", 32'(o_reg_addr), 32'd2);

        // two-clock SDA glitch with SCL high
        sda_m = 1'b0; wait_clks(2);
        sda_m = 1'b1; wait_clks(20);
        check("glitch_state", 32'(o_state), 32'(IDLE));
        check("glitch_busy", 32'(o_busy), 32'd0);

        // SCL held low mid-byte
        i2c_start();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        wait_clks(150);
`ifdef SMBUS_TARGET_SCL_TIMEOUT_EN
        check("to_busy", 32'(o_busy), 32'd0);
        check("to_oe", 32'(o_sda_oe), 32'd0);
        check("to_state", 32'(o_state), 32'(IDLE));
`else
        check("hold_busy", 32'(o_busy), 32'd1);
        check("hold_state", 32'(o_state), 32'(ADDR));
`endif
        i2c_stop();
        check("to_busy_end", 32'(o_busy), 32'd0);

        // reset during the address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(1'b0 ^ (8'hB4 >> i) & 1'b1);
        wait_clks(5);
        check("rst_ack_drive", 32'(o_sda_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_release_now", 32'(o_sda_oe), 32'd0);
        wait_clks(1);
        check("rst_mid_busy", 32'(o_busy), 32'd0);
        check("rst_mid_state", 32'(o_state), 32'(IDLE));
        check("rst_mid_addr", 32'(o_reg_addr), 32'd0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_clks(10);
        rst_n = 1'b1;
        wait_clks(10);
        compare_writes("rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
